// File: rtl/cim_gemv_engine.sv
// cim_gemv_engine: sequenced CIM matrix-vector engine, LANES MACs per word.
// Optional macro CIM_REQUANT_EN: round, shift and saturate results to DATA_WIDTH.
module cim_gemv_engine #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DIM_WIDTH-1:0]        dim_n,
  input  logic [DIM_WIDTH-1:0]        dim_k,
  input  logic [ADDR_WIDTH-1:0]       input_addr,
  input  logic [ADDR_WIDTH-1:0]       weight_addr,
  input  logic [ADDR_WIDTH-1:0]       output_addr,
  input  logic [4:0]                  cfg_shift,
  output logic                        mem_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [LANES*DATA_WIDTH-1:0] mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        irq,
  input  logic                        irq_clr
);

  localparam int DW = DATA_WIDTH;
  localparam int LW = LANES * DATA_WIDTH;
  localparam int IW = DIM_WIDTH + $clog2(LANES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_W,
    S_MAC,
    S_WR,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  n_q, n_d;
  logic [DIM_WIDTH-1:0]  kw_q, kw_d;
  logic [DIM_WIDTH-1:0]  dimn_q, dimn_d;
  logic [DIM_WIDTH-1:0]  dimk_q, dimk_d;
  logic [DIM_WIDTH-1:0]  wpr_q, wpr_d;
  logic [ADDR_WIDTH-1:0] xbase_q, xbase_d;
  logic [ADDR_WIDTH-1:0] rbase_q, rbase_d;
  logic [ADDR_WIDTH-1:0] obase_q, obase_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [LW-1:0]         xreg_q, xreg_d;
  logic                  errf_q, errf_d;
  logic                  irq_q, irq_d;

  logic [DIM_WIDTH-1:0]  wpr_c;
  logic [ACC_WIDTH-1:0]  lane_p [LANES];
  logic [ACC_WIDTH-1:0]  mac_sum;
  logic [ACC_WIDTH-1:0]  res_c;

  // words per row: ceil(K / LANES), no multiplier needed later
  assign wpr_c = DIM_WIDTH'(({1'b0, dim_k} + (DIM_WIDTH+1)'(LANES - 1))
                 / (DIM_WIDTH+1)'(LANES));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW-1:0]   xa;
    logic signed [DW-1:0]   wa;
    logic signed [2*DW-1:0] pr;
    logic [IW-1:0]          idx;
    logic                   on;
    assign xa  = xreg_q[l*DW +: DW];
    assign wa  = mem_rdata[l*DW +: DW];
    assign pr  = xa * wa;
    assign idx = IW'(kw_q) * IW'(LANES) + IW'(l);
    assign on  = idx < IW'(dimk_q);
    assign lane_p[l] = on ? ACC_WIDTH'(pr) : '0;
  end

  // adder tree over the lane products of the current word
  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      mac_sum = mac_sum + lane_p[i];
    end
  end

`ifdef CIM_REQUANT_EN
  localparam logic signed [ACC_WIDTH:0] RQ_MAX =
    (ACC_WIDTH+1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] RQ_MIN =
    -RQ_MAX - (ACC_WIDTH+1)'(1);

  logic [4:0]                shift_q, shift_d;
  logic signed [ACC_WIDTH:0] rq_rnd;
  logic signed [ACC_WIDTH:0] rq_sum;
  logic signed [ACC_WIDTH:0] rq_sh;

  // round half up, arithmetic shift, clamp to signed DW range
  always_comb begin
    rq_rnd = '0;
    if (shift_q != 5'd0) begin
      rq_rnd = (ACC_WIDTH+1)'(1) << (shift_q - 5'd1);
    end
    rq_sum = (ACC_WIDTH+1)'(signed'(acc_q)) + rq_rnd;
    rq_sh  = rq_sum >>> shift_q;
    if (rq_sh > RQ_MAX) begin
      res_c = ACC_WIDTH'(RQ_MAX);
    end else if (rq_sh < RQ_MIN) begin
      res_c = ACC_WIDTH'(RQ_MIN);
    end else begin
      res_c = ACC_WIDTH'(rq_sh);
    end
  end

  // shift amount is part of the job configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign shift_d = (state_q == S_IDLE && start && !abort) ? cfg_shift
                                                          : shift_q;
`else
  logic unused_shift;
  assign unused_shift = ^cfg_shift;
  assign res_c = acc_q;
`endif

  assign out_data = res_c;
  assign out_addr = obase_q + ADDR_WIDTH'(n_q);
  assign irq      = irq_q | done;

  // next-state and output decode for the job sequencer
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    kw_d      = kw_q;
    dimn_d    = dimn_q;
    dimk_d    = dimk_q;
    wpr_d     = wpr_q;
    xbase_d   = xbase_q;
    rbase_d   = rbase_q;
    obase_d   = obase_q;
    acc_d     = acc_q;
    xreg_d    = xreg_q;
    errf_d    = errf_q;
    irq_d     = irq_q;
    mem_en    = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dimn_d  = dim_n;
          dimk_d  = dim_k;
          wpr_d   = wpr_c;
          xbase_d = input_addr;
          rbase_d = weight_addr;
          obase_d = output_addr;
          kw_d    = '0;
          n_d     = '0;
          acc_d   = '0;
          if (dim_n == '0 || dim_k == '0) begin
            errf_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            errf_d  = 1'b0;
            state_d = S_RD_X;
          end
        end
      end
      S_RD_X: begin
        mem_en   = 1'b1;
        mem_addr = xbase_q + ADDR_WIDTH'(kw_q);
        state_d  = S_RD_W;
      end
      S_RD_W: begin
        mem_en   = 1'b1;
        mem_addr = rbase_q + ADDR_WIDTH'(kw_q);
        xreg_d   = mem_rdata;
        state_d  = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + mac_sum;
        if (kw_q == wpr_q - DIM_WIDTH'(1)) begin
          state_d = S_WR;
        end else begin
          kw_d    = kw_q + DIM_WIDTH'(1);
          state_d = S_RD_X;
        end
      end
      S_WR: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          kw_d    = '0;
          rbase_d = rbase_q + ADDR_WIDTH'(wpr_q);
          if (n_q == dimn_q - DIM_WIDTH'(1)) begin
            state_d = S_FIN;
          end else begin
            n_d     = n_q + DIM_WIDTH'(1);
            state_d = S_RD_X;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        err     = errf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_FIN) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // sequencer and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      kw_q    <= '0;
      dimn_q  <= '0;
      dimk_q  <= '0;
      wpr_q   <= '0;
      xbase_q <= '0;
      rbase_q <= '0;
      obase_q <= '0;
      acc_q   <= '0;
      xreg_q  <= '0;
      errf_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      kw_q    <= kw_d;
      dimn_q  <= dimn_d;
      dimk_q  <= dimk_d;
      wpr_q   <= wpr_d;
      xbase_q <= xbase_d;
      rbase_q <= rbase_d;
      obase_q <= obase_d;
      acc_q   <= acc_d;
      xreg_q  <= xreg_d;
      errf_q  <= errf_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_cim_gemv_engine.sv
// tb_cim_gemv_engine: directed jobs against a small SRAM model,
// results checked by a scoreboard monitor on the output port.
module tb_cim_gemv_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, irq_clr, out_ready;
  logic [15:0] dim_n, dim_k;
  logic [16:0] input_addr, weight_addr, output_addr;
  logic [4:0]  cfg_shift;
  logic        mem_en;
  logic [16:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [16:0] out_addr;
  logic [31:0] out_data;
  logic        busy, done, err, irq;

  typedef struct {
    logic [16:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mem [0:1023];
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          memen_cnt = 0;
  int          rd42 = 0, rd43 = 0, rd_oob = 0;

  always #5 clk = ~clk;

  cim_gemv_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dim_n(dim_n), .dim_k(dim_k),
    .input_addr(input_addr), .weight_addr(weight_addr),
    .output_addr(output_addr), .cfg_shift(cfg_shift),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .irq(irq),
    .irq_clr(irq_clr)
  );

  // SRAM model: one-cycle read latency, plus read-address bookkeeping
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:0]];
      memen_cnt++;
      if (mem_addr == 17'h42) rd42++;
      if (mem_addr == 17'h43) rd43++;
      if (mem_addr >= 17'h44 && mem_addr <= 17'h4f) rd_oob++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b,
                                     input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = 8'(a); b8 = 8'(b); c8 = 8'(c); d8 = 8'(d);
    return {d8, c8, b8, a8};
  endfunction

  function automatic longint expv(input longint acc, input int sh);
`ifdef CIM_REQUANT_EN
    longint r;
    r = acc + ((sh != 0) ? (longint'(1) << (sh - 1)) : 0);
    r = r >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
`else
    if (sh < 0) return 0;
    return acc;
`endif
  endfunction

  task automatic push(input logic [16:0] a, input longint acc,
                      input int sh);
    exp_t e;
    e.a = a;
    e.d = 32'(expv(acc, sh));
    sbq.push_back(e);
  endtask

  // scoreboard monitor: pop and compare on every accepted result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h@%0h want none",
                 out_data, out_addr);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_addr", 64'(out_addr), 64'(e.a));
        chk("result_data", 64'(out_data), 64'(e.d));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
  end

  task automatic kick(input int n, input int k, input logic [16:0] xa,
                      input logic [16:0] wa, input logic [16:0] oa,
                      input logic [4:0] sh);
    @(posedge clk); #1;
    dim_n       = 16'(n);
    dim_k       = 16'(k);
    input_addr  = xa;
    weight_addr = wa;
    output_addr = oa;
    cfg_shift   = sh;
    start       = 1'b1;
  endtask

  task automatic wait_done(input logic exp_err);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("err_at_done", 64'(err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int snap;
    rst = 1'b1; start = 0; abort = 0; irq_clr = 0; out_ready = 1;
    dim_n = 0; dim_k = 0; input_addr = 0; weight_addr = 0;
    output_addr = 0; cfg_shift = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem['h10] = pk(1, 2, 3, 4);
    mem['h20] = pk(5, 6, 7, 8);
    mem['h30] = pk(1, 1, 1, 1);
    mem['h31] = pk(1, 1, 99, 99);
    for (int i = 'h40; i < 'h44; i++) mem[i] = pk(2, 2, 2, 2);
    for (int i = 'h44; i < 'h48; i++) mem[i] = pk(50, 50, 50, 50);
    mem['h50] = pk(1, 2, 3, 4);
    mem['h51] = pk(5, 6, 7, 8);
    mem['h60] = pk(1, 1, 1, 1);
    mem['h61] = pk(2, 2, 2, 2);
    mem['h70] = pk(-128, -128, -128, -128);
    mem['h78] = pk(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_irq", 64'(irq), 0);
    chk("rst_out_data", 64'(out_data), 0);

    // basic dot product with cycle-exact timing
    push('h100, 70, 0);
    kick(1, 4, 'h10, 'h20, 'h100, 0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      if (c == 1) begin
        chk("t1_rdx_en", 64'(mem_en), 1);
        chk("t1_rdx_addr", 64'(mem_addr), 'h10);
        chk("t1_busy", 64'(busy), 1);
      end
      if (c == 2) chk("t1_rdw_addr", 64'(mem_addr), 'h20);
      if (c == 4) begin
        chk("t1_wr_valid", 64'(out_valid), 1);
        chk("t1_wr_mem_en", 64'(mem_en), 0);
      end
      if (c == 5) begin
        chk("t1_done", 64'(done), 1);
        chk("t1_irq", 64'(irq), 1);
        chk("t1_err", 64'(err), 0);
        chk("t1_fin_mem_en", 64'(mem_en), 0);
      end
      if (c == 6) chk("t1_idle", 64'(busy), 0);
    end
    exp_done++;

    // partial final word, two rows
    rd42 = 0; rd43 = 0; rd_oob = 0;
    push('h180, 12, 0);
    push('h181, 12, 0);
    kick(2, 6, 'h30, 'h40, 'h180, 0);
    @(posedge clk); #1 start = 0;
    wait_done(0);
    exp_done++;
    chk("t2_rd42", 64'(rd42), 1);
    chk("t2_rd43", 64'(rd43), 1);
    chk("t2_rd_oob", 64'(rd_oob), 0);

    // extreme operands, then shift 8, then unit vector
    push('h1a0, 65536, 0);
    kick(1, 4, 'h70, 'h70, 'h1a0, 0);
    @(posedge clk); #1 start = 0;
    wait_done(0);
    exp_done++;
    push('h1a1, 65536, 8);
    kick(1, 4, 'h70, 'h70, 'h1a1, 8);
    @(posedge clk); #1 start = 0;
    wait_done(0);
    exp_done++;
    push('h1a2, 1, 0);
    kick(1, 4, 'h78, 'h78, 'h1a2, 0);
    @(posedge clk); #1 start = 0;
    wait_done(0);
    exp_done++;

    // backpressure: out_ready low for three WR cycles
    out_ready = 0;
    push('h200, 70, 0);
    kick(1, 4, 'h10, 'h20, 'h200, 0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1 start = 0;
      if (c == 7) out_ready = 1;
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk("t4_hold_valid", 64'(out_valid), 1);
        chk("t4_hold_addr", 64'(out_addr), 'h200);
        chk("t4_hold_data", 64'(out_data), 64'(32'(expv(70, 0))));
        chk("t4_hold_mem_en", 64'(mem_en), 0);
        chk("t4_hold_done", 64'(done), 0);
      end
      if (c == 8) chk("t4_done_late", 64'(done), 1);
    end
    exp_done++;

    // zero dimension: error completion, irq_clr loses to done
    @(posedge clk); #1 irq_clr = 1;
    @(posedge clk); #1 irq_clr = 0;
    @(negedge clk);
    chk("t5_irq_cleared", 64'(irq), 0);
    snap = memen_cnt;
    kick(0, 4, 'h10, 'h20, 'h280, 0);
    @(posedge clk); #1 start = 0; irq_clr = 1;
    @(negedge clk);
    chk("t5_done", 64'(done), 1);
    chk("t5_err", 64'(err), 1);
    chk("t5_irq", 64'(irq), 1);
    @(posedge clk); #1 irq_clr = 0;
    @(negedge clk);
    chk("t5_irq_sticky", 64'(irq), 1);
    chk("t5_no_mem_en", 64'(memen_cnt - snap), 0);
    exp_done++;

    // abort in MAC, restart, ignored start while busy
    kick(1, 8, 'h50, 'h60, 'h300, 0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1 start = 0;
      if (c == 3) abort = 1;
    end
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("t6_abort_idle", 64'(busy), 0);
    chk("t6_abort_mem_en", 64'(mem_en), 0);
    snap = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done", 64'(done_cnt - snap), 0);
    push('h300, 62, 0);
    kick(1, 8, 'h50, 'h60, 'h300, 0);
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 start = 1; dim_n = 0; dim_k = 0;
    @(posedge clk); #1 start = 0;
    wait_done(0);
    exp_done++;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 0);
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cim_gemv_engine.md
Name: cim_gemv_engine

Overview:
Parametrised successor to the single-MAC CIM datapath. Sequenced matrix-vector engine that computes y[n] = sum over k of x[k]*W[n][k], for n < N and k < K.
- Fetches packed int operands from the CIM SRAM read port into LANES parallel MACs and accumulates over K.
- Handles a partial final word per row.
- Streams each result to an output port with backpressure.
- Sits between the CIM controller (config/start/irq) and the CIM SRAM.

Parameters:
LANES, 4, MAC lanes per cycle; elements packed per SRAM word
DATA_WIDTH, 8, signed element width
ACC_WIDTH, 32, accumulator and result width
ADDR_WIDTH, 17, SRAM word-address width
DIM_WIDTH, 16, width of the N and K dimension registers

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  1-cycle pulse; sampled only in IDLE
abort  in  1  return to IDLE next cycle
dim_n  in  DIM_WIDTH  output rows N, latched at start
dim_k  in  DIM_WIDTH  reduction length K in elements, latched at start
input_addr  in  ADDR_WIDTH  x base word address, latched
weight_addr  in  ADDR_WIDTH  W base word address (row-major), latched
output_addr  in  ADDR_WIDTH  y base address, latched
cfg_shift  in  5  requant shift, latched (used only with macro)
mem_en  out  1  SRAM read enable
mem_addr  out  ADDR_WIDTH  SRAM read address
mem_rdata  in  LANES*DATA_WIDTH  read data, valid exactly 1 cycle after mem_en; lane l = bits [l*DW +: DW]
out_valid  out  1  result valid
out_ready  in  1  result accepted when out_valid && out_ready
out_addr  out  ADDR_WIDTH  output_addr + n
out_data  out  ACC_WIDTH  result
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at job end
err  out  1  1-cycle pulse with done when N==0 or K==0
irq  out  1  sticky, set by done
irq_clr  in  1  clears irq; set wins if coincident with done

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator 0, irq 0.
- Word count: wpr = ceil(K/LANES), computed at start. Row base starts at weight_addr and advances by wpr per row; no multiplier.
- FSM states: IDLE, RD_X, RD_W, MAC, WR, FIN.
  - IDLE: on start with N,K != 0: latch config, kw=0, n=0, acc=0, go to RD_X. If N==0 or K==0: go to FIN with error flag set, no mem_en.
  - RD_X: mem_en=1, mem_addr = input_addr + kw.
  - RD_W: mem_en=1, mem_addr = row_base + kw; capture mem_rdata into x_reg.
  - MAC: acc += sum over l of x_reg[l]*mem_rdata[l].
    - Lane l is masked to 0 when kw*LANES + l >= K.
    - If kw == wpr-1 go to WR, else kw++ and go to RD_X.
  - WR: out_valid=1; out_addr/out_data held stable until handshake.
    - On handshake: acc=0, kw=0, row_base += wpr.
    - If n == N-1 go to FIN, else n++ and go to RD_X.
  - FIN: done=1 (err=1 if flagged), irq set; next state IDLE.
- Timing: 3 cycles per word. Start sampled at cycle 0 with N=1, K<=LANES and out_ready=1 gives WR at cycle 4, done at cycle 5.
- Arithmetic: signed DW×DW products, sign-extended to ACC_WIDTH, wrap modulo 2^ACC_WIDTH. Address sums wrap modulo 2^ADDR_WIDTH.
- Start while busy: ignored.
- Abort in any state: next cycle IDLE, out_valid=0, mem_en=0, no done. Abort has priority over start in the same cycle.
- Reset mid-operation: immediate return to reset values.
- mem_en is never high in IDLE, WR or FIN.

Optional Feature:
CIM_REQUANT_EN.
- Defined: out_data = sign-extend(sat_DW((acc + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift)). Rounding add is done in ACC_WIDTH+1 bits; saturation bounds are ±(2^(DW-1)) limits.
- Undefined: out_data = acc raw; cfg_shift ignored.

Test Plan:
- LANES=4, N=1, K=4, x=[1,2,3,4], W=[5,6,7,8], out_ready=1 -> out_data=70 at output_addr in cycle 4; done and irq at cycle 5; err=0.
- K=6, x words [1,1,1,1],[1,1,99,99], all W=2, N=2 -> two results of 12 at output_addr and output_addr+1; lanes 2–3 of word 1 masked; second row reads weight_addr+2 and +3.
- x=W=-128 ×4, N=1, K=4 -> raw 65536. With CIM_REQUANT_EN and shift=8 -> 127 (saturated). With shift=0 and x=W=[1,0,0,0] -> 1.
- out_ready held low 3 cycles in WR -> out_valid/out_addr/out_data stable, mem_en=0, done delayed exactly 3 cycles.
- start with dim_n=0 -> done=1 and err=1 one cycle later, mem_en never asserted; irq_clr coincident with that done -> irq=1.
- abort in MAC of a K=8 job, then restart with same config -> no done for aborted job; restarted job yields correct sum; start pulsed while busy has no effect.
